// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative MIPS multiply/divide sequencer owning HI/LO
module mdu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam int         STEPS    = 32;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic        r_is_div;
    logic        r_neg_a;
    logic        r_neg_r;
    logic        r_dz;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_div_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_accept = start && (r_state == S_IDLE) && !cancel;
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_a_neg  = w_signed && in1[31];
    assign w_b_neg  = w_signed && in2[31];
    assign w_abs_a  = w_a_neg ? (32'd0 - in1) : in1;
    assign w_abs_b  = w_b_neg ? (32'd0 - in2) : in2;

    // Multiply: upper half accumulates, lower half holds the multiplier shifting out.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: upper half is the partial remainder, lower half dividend->quotient.
    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_next  = w_div_ge ? {w_div_diff[31:0], r_acc[30:0], 1'b1}
                                  : {w_div_shift[31:0], r_acc[30:0], 1'b0};

    // A zero divisor leaves |in1| in the remainder and all ones in the quotient.
    assign w_prod_fix = r_neg_a ? (64'd0 - r_acc) : r_acc;
    assign w_quo_fix  = (r_neg_a && !r_dz) ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem_fix  = (r_neg_r && !r_dz) ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && !op[2]) w_next = S_CALC;
            S_CALC: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (r_count == 5'(STEPS - 1)) begin
                    w_next = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 5'd0;
            r_acc    <= 64'd0;
            r_opb    <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_acc    <= {32'd0, w_abs_a};
                                r_opb    <= w_abs_b;
                                r_is_div <= op[1];
                                r_neg_a  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_dz     <= (in2 == 32'd0);
                                r_count  <= 5'd0;
                            end
                            OP_MTHI: r_hi <= in1;
                            OP_MTLO: r_lo <= in1;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (!cancel) begin
                        r_acc   <= r_is_div ? w_div_next : w_mul_next;
                        r_count <= r_count + 5'd1;
                    end
                end
                S_FIN: begin
                    if (!cancel) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[63:32];
                            r_lo <= w_prod_fix[31:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq
module tb_mdu_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] sb_q[$];

    mdu_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .in1    (in1),
        .in2    (in2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        int busy_cnt;
        int done_cnt;
        int done_cyc;
        logic [63:0] exp;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        sb_q.push_back({ehi, elo});
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = n;
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    chk({name, " hi:lo"}, {hi, lo}, exp);
                end
            end
        end
        chk({name, " busy cycles"}, 64'(busy_cnt), 64'd33);
        chk({name, " done count"}, 64'(done_cnt), 64'd1);
        chk({name, " done cycle"}, 64'(done_cyc), 64'd34);
        if (sb_q.size() != 0) begin
            chk({name, " result missing"}, 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    task automatic do_move(input logic [2:0] o, input logic [31:0] d, input string name);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        in1   = d;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({name, " value"}, {32'd0, (o == 3'd4) ? hi : lo}, {32'd0, d});
        chk({name, " busy"}, {63'd0, busy}, 64'd0);
        chk({name, " done"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int busy_hi;
        int done_seen;

        vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[6] = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[7] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        in1    = 32'd0;
        in2    = 32'd0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo,
                   $sformatf("vec%0d", i));
        end

        do_move(3'd5, 32'h00001234, "mtlo");
        do_move(3'd4, 32'h0000AAAA, "mthi");
        do_move(3'd5, 32'h00005555, "mtlo2");

        // Cancel mid-multiply while a stray MTHI start is being ignored.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        in1   = 32'd3;
        in2   = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        busy_hi = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (busy) busy_hi++;
            if (n < 10) begin
                start = 1'b1;
                op    = 3'd4;
                in1   = 32'hDEAD;
            end else begin
                start  = 1'b0;
                cancel = 1'b1;
            end
        end
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cancel busy held", 64'(busy_hi), 64'd10);
        chk("cancel busy low", {63'd0, busy}, 64'd0);
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("cancel no done", 64'(done_seen), 64'd0);
        chk("cancel hi:lo kept", {hi, lo}, {32'h0000AAAA, 32'h00005555});

        // Asynchronous reset between edges in the middle of a divide.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd3;
        in1   = 32'd1000;
        in2   = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async busy", {63'd0, busy}, 64'd0);
        chk("async done", {63'd0, done}, 64'd0);
        chk("async hi", {32'd0, hi}, 64'd0);
        chk("async lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "post-reset divu");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
